// File: rtl/id_pipe_pkg.sv
// Shared types and helpers for the ID1/ID2 multi-lane pipeline register.
package id_pipe_pkg;

   localparam int CNT_W_DEF     = 16;
   localparam int STALL_MAX_DEF = 64;
   localparam int CTRL_W_DEF    = 16;

   localparam int CTRL_SIGN_EXT   = 0;
   localparam int CTRL_ALU_OP     = 1;
   localparam int CTRL_REG_DST    = 5;
   localparam int CTRL_MEM_TO_REG = 7;
   localparam int CTRL_PC_SRC     = 9;
   localparam int CTRL_BRANCH     = 10;
   localparam int CTRL_JUMP       = 11;
   localparam int CTRL_ALU_SRC    = 12;
   localparam int CTRL_REG_WRITE  = 13;
   localparam int CTRL_MEM_WRITE  = 14;
   localparam int CTRL_MEM_READ   = 15;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       alu_src;
      logic       jump;
      logic       branch;
      logic       pc_src;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic [3:0] alu_op;
      logic       sign_ext;
   } ctrl_t;

   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/id_pipe_reg_nlane_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/id_pipe_reg_nlane.sv
// N-lane ID1/ID2 pipeline register with hold-on-stall,
// age-ordered kill, perf counters and a stall watchdog.
module id_pipe_reg_nlane
   import id_pipe_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int INSTR_W   = 32,
   parameter int PC_W      = 8,
   parameter int CTRL_W    = CTRL_W_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int STALL_MAX = STALL_MAX_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [LANES-1:0]          in_valid,
   input  logic [LANES*INSTR_W-1:0]  in_instr,
   input  logic [LANES*PC_W-1:0]     in_pc_plus,
   input  logic [LANES*PC_W-1:0]     in_pc_branch,
   input  logic [LANES-1:0]          in_pred,
   input  logic [LANES*CTRL_W-1:0]   in_ctrl,
   input  logic                      flush_all,
   input  logic [LANES-1:0]          kill_younger,
   input  logic                      stall,
   input  logic [LANES-1:0]          bubble,
   output logic [LANES-1:0]          out_valid,
   output logic [LANES*INSTR_W-1:0]  out_instr,
   output logic [LANES*PC_W-1:0]     out_pc_plus,
   output logic [LANES*PC_W-1:0]     out_pc_branch,
   output logic [LANES-1:0]          out_pred,
   output logic [LANES*CTRL_W-1:0]   out_ctrl,
   output logic [CNT_W-1:0]          flush_cnt,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic [CNT_W-1:0]          bubble_cnt,
   output logic                      stall_timeout
);

   logic [LANES-1:0] kill;
   logic [LANES-1:0] eff_valid;
   logic             drop;
   logic             acc;
   logic             do_stall;
   logic             do_load;
   logic [CNT_W-1:0] run_cnt;

   assign do_stall = stall & ~flush_all;
   assign do_load  = ~stall & ~flush_all;

   // Older lanes that resolve a jump kill every younger lane.
   always_comb begin
      kill      = '0;
      eff_valid = '0;
      drop      = 1'b0;
      acc       = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         kill[j]      = acc;
         eff_valid[j] = in_valid[j] & ~bubble[j] & ~acc;
         if (in_valid[j] & (bubble[j] | acc))
            drop = 1'b1;
         acc = acc | (kill_younger[j] & in_valid[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush_all) begin
         out_valid     <= '0;
         out_instr     <= '0;
         out_pc_plus   <= '0;
         out_pc_branch <= '0;
         out_pred      <= '0;
         out_ctrl      <= '0;
      end else if (!stall) begin
         for (int j = 0; j < LANES; j++) begin
            out_valid[j] <= eff_valid[j];
            out_pred[j]  <= eff_valid[j] & in_pred[j];
            out_instr[lane_lo(j, INSTR_W) +: INSTR_W] <=
               eff_valid[j] ?
               in_instr[lane_lo(j, INSTR_W) +: INSTR_W] : '0;
            out_pc_plus[lane_lo(j, PC_W) +: PC_W] <=
               eff_valid[j] ?
               in_pc_plus[lane_lo(j, PC_W) +: PC_W] : '0;
            out_pc_branch[lane_lo(j, PC_W) +: PC_W] <=
               eff_valid[j] ?
               in_pc_branch[lane_lo(j, PC_W) +: PC_W] : '0;
            out_ctrl[lane_lo(j, CTRL_W) +: CTRL_W] <=
               eff_valid[j] ?
               in_ctrl[lane_lo(j, CTRL_W) +: CTRL_W] : '0;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (flush_all),
      .count (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (do_stall),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (do_load & drop),
      .count (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (~do_stall),
      .inc   (do_stall),
      .count (run_cnt)
   );

   // Fires on the edge where the run count becomes STALL_MAX.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_timeout <= 1'b0;
      end else if (do_stall &&
                   (run_cnt == CNT_W'(STALL_MAX - 1))) begin
         stall_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_pipe_reg_nlane.sv
// Self-checking bench: directed plan plus random traffic
// against a lane-level reference model, two configurations.
module tb_id_pipe_reg_nlane;
   import id_pipe_pkg::*;

   localparam int L  = 2;
   localparam int IW = 32;
   localparam int PW = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic reset;
   logic [L-1:0]    in_valid;
   logic [L*IW-1:0] in_instr;
   logic [L*PW-1:0] in_pc_plus;
   logic [L*PW-1:0] in_pc_branch;
   logic [L-1:0]    in_pred;
   logic [L*CW-1:0] in_ctrl;
   logic            flush_all;
   logic [L-1:0]    kill_younger;
   logic            stall;
   logic [L-1:0]    bubble;

   logic [L-1:0]    a_valid, b_valid;
   logic [L*IW-1:0] a_instr, b_instr;
   logic [L*PW-1:0] a_pp, b_pp;
   logic [L*PW-1:0] a_pb, b_pb;
   logic [L-1:0]    a_pred, b_pred;
   logic [L*CW-1:0] a_ctrl, b_ctrl;
   logic [15:0]     a_fc, a_sc, a_bc;
   logic [2:0]      b_fc, b_sc, b_bc;
   logic            a_to, b_to;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_pipe_reg_nlane u_dut_a (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_instr(in_instr),
      .in_pc_plus(in_pc_plus), .in_pc_branch(in_pc_branch),
      .in_pred(in_pred), .in_ctrl(in_ctrl),
      .flush_all(flush_all), .kill_younger(kill_younger),
      .stall(stall), .bubble(bubble),
      .out_valid(a_valid), .out_instr(a_instr),
      .out_pc_plus(a_pp), .out_pc_branch(a_pb),
      .out_pred(a_pred), .out_ctrl(a_ctrl),
      .flush_cnt(a_fc), .stall_cnt(a_sc),
      .bubble_cnt(a_bc), .stall_timeout(a_to)
   );

   id_pipe_reg_nlane #(.CNT_W(3), .STALL_MAX(4)) u_dut_b (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_instr(in_instr),
      .in_pc_plus(in_pc_plus), .in_pc_branch(in_pc_branch),
      .in_pred(in_pred), .in_ctrl(in_ctrl),
      .flush_all(flush_all), .kill_younger(kill_younger),
      .stall(stall), .bubble(bubble),
      .out_valid(b_valid), .out_instr(b_instr),
      .out_pc_plus(b_pp), .out_pc_branch(b_pb),
      .out_pred(b_pred), .out_ctrl(b_ctrl),
      .flush_cnt(b_fc), .stall_cnt(b_sc),
      .bubble_cnt(b_bc), .stall_timeout(b_to)
   );

   // Reference state: one payload set, two counter sets.
   bit          m_v    [L];
   logic [31:0] m_instr[L];
   logic [7:0]  m_pp   [L];
   logic [7:0]  m_pb   [L];
   bit          m_pred [L];
   logic [15:0] m_ctrl [L];
   int m_fc[2], m_sc[2], m_bc[2], m_run[2];
   bit m_to[2];
   int cmax[2] = '{65535, 7};
   int smax[2] = '{64, 4};

   function automatic int sat_inc(int v, int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic model();
      bit killed;
      bit drop;
      bit eff;
      if (reset) begin
         for (int j = 0; j < L; j++) begin
            m_v[j] = 0; m_instr[j] = 0; m_pp[j] = 0;
            m_pb[j] = 0; m_pred[j] = 0; m_ctrl[j] = 0;
         end
         for (int c = 0; c < 2; c++) begin
            m_fc[c] = 0; m_sc[c] = 0; m_bc[c] = 0;
            m_run[c] = 0; m_to[c] = 0;
         end
      end else if (flush_all) begin
         for (int j = 0; j < L; j++) begin
            m_v[j] = 0; m_instr[j] = 0; m_pp[j] = 0;
            m_pb[j] = 0; m_pred[j] = 0; m_ctrl[j] = 0;
         end
         for (int c = 0; c < 2; c++) begin
            m_fc[c] = sat_inc(m_fc[c], cmax[c]);
            m_run[c] = 0;
         end
      end else if (stall) begin
         for (int c = 0; c < 2; c++) begin
            m_sc[c] = sat_inc(m_sc[c], cmax[c]);
            m_run[c] = sat_inc(m_run[c], cmax[c]);
            if (m_run[c] == smax[c]) m_to[c] = 1;
         end
      end else begin
         killed = 0;
         drop = 0;
         for (int j = 0; j < L; j++) begin
            eff = in_valid[j] && !bubble[j] && !killed;
            if (in_valid[j] && (bubble[j] || killed)) drop = 1;
            m_v[j] = eff;
            m_instr[j] = eff ? in_instr[j*IW +: IW] : 32'h0;
            m_pp[j] = eff ? in_pc_plus[j*PW +: PW] : 8'h0;
            m_pb[j] = eff ? in_pc_branch[j*PW +: PW] : 8'h0;
            m_pred[j] = eff ? in_pred[j] : 1'b0;
            m_ctrl[j] = eff ? in_ctrl[j*CW +: CW] : 16'h0;
            if (kill_younger[j] && in_valid[j]) killed = 1;
         end
         for (int c = 0; c < 2; c++) begin
            if (drop) m_bc[c] = sat_inc(m_bc[c], cmax[c]);
            m_run[c] = 0;
         end
      end
   endtask

   task automatic chk(string tag, logic [63:0] obs,
                      logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [L-1:0]    ev;
      logic [L*IW-1:0] ei;
      logic [L*PW-1:0] epp, epb;
      logic [L-1:0]    epr;
      logic [L*CW-1:0] ec;
      for (int j = 0; j < L; j++) begin
         ev[j] = m_v[j];
         ei[j*IW +: IW] = m_instr[j];
         epp[j*PW +: PW] = m_pp[j];
         epb[j*PW +: PW] = m_pb[j];
         epr[j] = m_pred[j];
         ec[j*CW +: CW] = m_ctrl[j];
      end
      chk("a_valid", 64'(a_valid), 64'(ev));
      chk("a_instr", a_instr, ei);
      chk("a_pc_plus", 64'(a_pp), 64'(epp));
      chk("a_pc_branch", 64'(a_pb), 64'(epb));
      chk("a_pred", 64'(a_pred), 64'(epr));
      chk("a_ctrl", 64'(a_ctrl), 64'(ec));
      chk("b_valid", 64'(b_valid), 64'(ev));
      chk("b_instr", b_instr, ei);
      chk("b_ctrl", 64'(b_ctrl), 64'(ec));
      chk("a_flush_cnt", 64'(a_fc), 64'(m_fc[0]));
      chk("a_stall_cnt", 64'(a_sc), 64'(m_sc[0]));
      chk("a_bubble_cnt", 64'(a_bc), 64'(m_bc[0]));
      chk("a_timeout", 64'(a_to), 64'(m_to[0]));
      chk("b_flush_cnt", 64'(b_fc), 64'(m_fc[1]));
      chk("b_stall_cnt", 64'(b_sc), 64'(m_sc[1]));
      chk("b_bubble_cnt", 64'(b_bc), 64'(m_bc[1]));
      chk("b_timeout", 64'(b_to), 64'(m_to[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model();
      #1;
      check_all();
   endtask

   task automatic rand_payload();
      ctrl_t c0, c1;
      c0 = ctrl_t'($urandom);
      c1 = ctrl_t'($urandom);
      in_valid = L'($urandom);
      in_instr = {$urandom, $urandom};
      in_pc_plus = 16'($urandom);
      in_pc_branch = 16'($urandom);
      in_pred = L'($urandom);
      in_ctrl = {c1, c0};
   endtask

   task automatic rand_all();
      rand_payload();
      reset = ($urandom_range(0, 59) == 0);
      flush_all = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      kill_younger = ($urandom_range(0, 2) == 0) ?
                     L'($urandom) : '0;
      bubble = ($urandom_range(0, 3) == 0) ?
               L'($urandom) : '0;
   endtask

   initial begin
      in_valid = '0; in_instr = '0; in_pc_plus = '0;
      in_pc_branch = '0; in_pred = '0; in_ctrl = '0;
      flush_all = 0; kill_younger = '0; stall = 0;
      bubble = '0;
      reset = 1;
      tick();
      tick();
      reset = 0;

      in_valid = 2'b11;
      in_instr = {32'h20020007, 32'h20010005};
      in_pc_plus = {8'h05, 8'h04};
      in_pc_branch = {8'h40, 8'h30};
      in_pred = 2'b10;
      in_ctrl = {16'h2001, 16'h8003};
      tick();

      stall = 1;
      repeat (3) begin
         rand_payload();
         tick();
      end
      stall = 0;

      rand_payload();
      in_valid = 2'b11;
      kill_younger = 2'b01;
      tick();
      rand_payload();
      in_valid = 2'b11;
      kill_younger = 2'b10;
      tick();
      kill_younger = '0;

      rand_payload();
      in_valid = 2'b11;
      tick();
      flush_all = 1;
      stall = 1;
      tick();
      flush_all = 0;
      stall = 0;

      rand_payload();
      in_valid = 2'b11;
      tick();
      stall = 1;
      repeat (4) tick();
      stall = 0;
      tick();
      tick();
      reset = 1;
      tick();
      reset = 0;

      in_valid = 2'b01;
      bubble = 2'b01;
      repeat (10) tick();
      reset = 1;
      tick();
      reset = 0;
      bubble = '0;

      rand_payload();
      tick();
      stall = 1;
      repeat (66) tick();
      stall = 0;
      tick();

      repeat (400) begin
         rand_all();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
